usb_rx_packet_ctrl: RTL and testbench
=====================================

Name: usb_rx_packet_ctrl

Overview:
Sequences the USB receive byte stream from the RX datapath, one packet at a time.
- Pulls bytes over the rxAcceptNewData/rxDataValid handshake, validates and classifies the PID, and decodes token fields.
- Streams DATA-packet payload into a downstream buffer write port and reports a per-packet result.
- Owns USB bus-reset acknowledgement.
- Sits between the RX datapath and the endpoint/protocol logic, in the clk48 domain.

Parameters:
MAX_PAYLOAD, 64, maximum DATA payload bytes, excluding the 2 CRC16 bytes; range 1..1023.
CNT_W, 11, width of byte counters; must hold MAX_PAYLOAD+2.

Ports:
CLK  input  1  48 MHz clock.
rst_n  input  1  synchronous, active-low reset.
usbResetDetect  input  1  bus reset seen by the RX datapath.
ACK_USB_RST  output  1  one-cycle acknowledge of usbResetDetect.
rxAcceptNewData  output  1  controller can take a byte.
rxDataValid  input  1  rxData valid.
rxData  input  8  received byte.
rxIsLastByte  input  1  current byte is the last of the packet.
keepPacket  input  1  packet integrity result; sampled with the last byte.
rxEnable  input  1  protocol logic allows reception; low while transmitting.
bufWrEn  output  1  write payload byte.
bufWrData  output  8  payload byte, including CRC16 bytes.
bufFull  input  1  buffer cannot accept a write this cycle.
pktDone  output  1  one-cycle pulse at packet end.
pktOk  output  1  valid with pktDone.
pktPid  output  4  PID[3:0] of the last packet; held until the next pktDone.
tokAddr  output  7  token address; held.
tokEndp  output  4  token endpoint; held.
pktLen  output  CNT_W  bytes after PID; held.
busReset  output  1  one-cycle pulse on bus-reset acknowledge.

Behaviour:
- Reset (rst_n=0 at a CLK edge): state IDLE.
  - All outputs 0: rxAcceptNewData, bufWrEn, pktDone, pktOk, ACK_USB_RST, busReset.
  - pktPid, tokAddr, tokEndp, pktLen, bufWrData cleared to 0.
- Transfer rule: a byte transfers on a cycle where rxDataValid && rxAcceptNewData. rxAcceptNewData is registered; there is no combinational path from rxDataValid.
- States:
  - IDLE: rxAcceptNewData=rxEnable. On transfer → check PID, rxData[7:4]==~rxData[3:0]; latch PID; clear the counter.
    - Last byte: a handshake PID (type bits[1:0]=2'b10) with keepPacket → DONE ok. Any other PID → DONE fail.
    - Not last: PID bad → DRAIN. Token (type 01) → TOK1. Data (type 11) → DATA. Handshake or special → DRAIN (error).
  - TOK1: on transfer → tokAddr=rxData[6:0], tokEndp[0]=rxData[7]. Last byte → DONE fail; otherwise → TOK2.
  - TOK2: on transfer → tokEndp[3:1]=rxData[2:0]. Ok = last byte && keepPacket. Not last → DRAIN (error).
  - DATA: rxAcceptNewData=!bufFull. Each transfer → bufWrEn=1 and bufWrData=rxData in the next cycle; count +1.
    - Count would exceed MAX_PAYLOAD+2 → DRAIN (error); the byte is not written.
    - On the last byte: ok = keepPacket && count>=2.
  - DRAIN: rxAcceptNewData=1, nothing written. The error flag stays sticky. Last byte → DONE fail.
  - DONE: one cycle; pktDone=1, pktOk=result, pktLen=count. Then → IDLE. rxAcceptNewData=0 in DONE.
- Field latching: pktPid, tokAddr and tokEndp are exposed only at DONE; they are staged internally while the packet is in progress.
- Latency: pktDone rises 2 cycles after the last byte transfer.
- Bus reset: usbResetDetect=1 overrides everything, including mid-packet.
  - State → IDLE; no pktDone for the aborted packet.
  - ACK_USB_RST and busReset pulse for exactly one cycle.
  - No re-pulse until usbResetDetect has been seen low.
- rxEnable low mid-packet: no effect; gating applies in IDLE only.
- pktLen: counts bytes after the PID, saturating at MAX_PAYLOAD+3.

Test Plan:
- ACK handshake, byte 0xD2 last, keepPacket=1 → pktDone 2 cycles later; pktOk=1, pktPid=2, pktLen=0, no bufWrEn.
- IN token, bytes 0x69, 0x85, 0x0B (last, keep=1) → pktOk=1, tokAddr=0x05, tokEndp=0x7 (bit0=1 from 0x85[7], bits[3:1]=3 from 0x0B[2:0]).
- DATA0 0xC3 followed by 4 payload bytes plus 2 CRC bytes, bufFull toggled every other cycle → exactly 6 bufWrEn pulses in order; no write while full; pktLen=6, pktOk=1.
- Bad PID 0xC4 followed by 3 bytes → DRAIN; pktDone with pktOk=0; zero writes.
- DATA with MAX_PAYLOAD=4 and 8 bytes after the PID → first 6 written; pktOk=0, pktLen=7 (saturated at MAX_PAYLOAD+3).
- usbResetDetect asserted mid-DATA for 10 cycles → single ACK_USB_RST/busReset pulse; no pktDone; next ACK packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_packet_ctrl_if.sv
// rtl/usb_rx_packet_ctrl_if.sv - byte-stream, payload-buffer and packet-result signals of the USB RX packet controller
interface usb_rx_packet_ctrl_if #(
    parameter int CNT_W = 11
) ();
    logic             usbResetDetect;
    logic             ACK_USB_RST;
    logic             rxAcceptNewData;
    logic             rxDataValid;
    logic [7:0]       rxData;
    logic             rxIsLastByte;
    logic             keepPacket;
    logic             rxEnable;
    logic             bufWrEn;
    logic [7:0]       bufWrData;
    logic             bufFull;
    logic             pktDone;
    logic             pktOk;
    logic [3:0]       pktPid;
    logic [6:0]       tokAddr;
    logic [3:0]       tokEndp;
    logic [CNT_W-1:0] pktLen;
    logic             busReset;

    modport slave (
        input  usbResetDetect, rxDataValid, rxData, rxIsLastByte, keepPacket, rxEnable, bufFull,
        output ACK_USB_RST, rxAcceptNewData, bufWrEn, bufWrData, pktDone, pktOk, pktPid,
               tokAddr, tokEndp, pktLen, busReset
    );

    modport master (
        output usbResetDetect, rxDataValid, rxData, rxIsLastByte, keepPacket, rxEnable, bufFull,
        input  ACK_USB_RST, rxAcceptNewData, bufWrEn, bufWrData, pktDone, pktOk, pktPid,
               tokAddr, tokEndp, pktLen, busReset
    );
endinterface

// File: rtl/usb_rx_packet_ctrl.sv
// rtl/usb_rx_packet_ctrl.sv - USB receive packet sequencer: PID check, token decode, DATA payload streaming
module usb_rx_packet_ctrl #(
    parameter int MAX_PAYLOAD = 64,
    parameter int CNT_W       = 11
) (
    input  logic                CLK,
    input  logic                rst_n,
    usb_rx_packet_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, TOK1, TOK2, DATA, DRAIN, DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_PAYLOAD + 3);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    state_e           state_q, state_d;
    logic             accept_q, accept_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ok_q, ok_d;
    logic [3:0]       pid_q, pid_d;
    logic [6:0]       addr_q, addr_d;
    logic [3:0]       endp_q, endp_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic             pkt_ok_q, pkt_ok_d;
    logic [3:0]       pkt_pid_q, pkt_pid_d;
    logic [6:0]       tok_addr_q, tok_addr_d;
    logic [3:0]       tok_endp_q, tok_endp_d;
    logic [CNT_W-1:0] pkt_len_q, pkt_len_d;
    logic             ack_q, ack_d;
    logic             rst_seen_q;
    logic             xfer, pid_good;
    logic [1:0]       pid_type;

    assign xfer     = bus.rxDataValid && accept_q;
    assign pid_good = (bus.rxData[7:4] == ~bus.rxData[3:0]);
    assign pid_type = bus.rxData[1:0];
    assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        accept_d   = 1'b0;
        cnt_d      = cnt_q;
        ok_d       = ok_q;
        pid_d      = pid_q;
        addr_d     = addr_q;
        endp_d     = endp_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        pkt_ok_d   = 1'b0;
        pkt_pid_d  = pkt_pid_q;
        tok_addr_d = tok_addr_q;
        tok_endp_d = tok_endp_q;
        pkt_len_d  = pkt_len_q;
        ack_d      = bus.usbResetDetect && !rst_seen_q;

        case (state_q)
            IDLE: if (xfer) begin
                cnt_d = '0;
                pid_d = bus.rxData[3:0];
                ok_d  = 1'b0;
                if (bus.rxIsLastByte) begin
                    ok_d    = pid_good && (pid_type == 2'b10) && bus.keepPacket;
                    state_d = DONE;
                end else if (!pid_good) begin
                    state_d = DRAIN;
                end else begin
                    case (pid_type)
                        2'b01:   state_d = TOK1;
                        2'b11:   state_d = DATA;
                        default: state_d = DRAIN;
                    endcase
                end
            end
            TOK1: if (xfer) begin
                cnt_d     = cnt_inc;
                addr_d    = bus.rxData[6:0];
                endp_d[0] = bus.rxData[7];
                state_d   = bus.rxIsLastByte ? DONE : TOK2;
            end
            TOK2: if (xfer) begin
                cnt_d       = cnt_inc;
                endp_d[3:1] = bus.rxData[2:0];
                ok_d        = bus.rxIsLastByte && bus.keepPacket;
                state_d     = bus.rxIsLastByte ? DONE : DRAIN;
            end
            DATA: if (xfer) begin
                cnt_d = cnt_inc;
                // A byte beyond payload+CRC is dropped, not written.
                if (cnt_inc > CNT_LIMIT) begin
                    ok_d    = 1'b0;
                    state_d = bus.rxIsLastByte ? DONE : DRAIN;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = bus.rxData;
                    if (bus.rxIsLastByte) begin
                        ok_d    = bus.keepPacket && (cnt_inc >= CNT_TWO);
                        state_d = DONE;
                    end
                end
            end
            DRAIN: if (xfer) begin
                cnt_d = cnt_inc;
                ok_d  = 1'b0;
                if (bus.rxIsLastByte) state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                pkt_ok_d   = ok_q;
                pkt_pid_d  = pid_q;
                tok_addr_d = addr_q;
                tok_endp_d = endp_q;
                pkt_len_d  = cnt_q;
            end
            default: state_d = IDLE;
        endcase

        // Bus reset aborts the packet outright: no result is published for it.
        if (bus.usbResetDetect) begin
            state_d    = IDLE;
            wr_en_d    = 1'b0;
            done_d     = 1'b0;
            pkt_ok_d   = 1'b0;
            pkt_pid_d  = pkt_pid_q;
            tok_addr_d = tok_addr_q;
            tok_endp_d = tok_endp_q;
            pkt_len_d  = pkt_len_q;
        end

        case (state_d)
            IDLE:    accept_d = bus.rxEnable && !bus.usbResetDetect;
            DATA:    accept_d = !bus.bufFull;
            DONE:    accept_d = 1'b0;
            default: accept_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            accept_q   <= 1'b0;
            cnt_q      <= '0;
            ok_q       <= 1'b0;
            pid_q      <= '0;
            addr_q     <= '0;
            endp_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            pkt_ok_q   <= 1'b0;
            pkt_pid_q  <= '0;
            tok_addr_q <= '0;
            tok_endp_q <= '0;
            pkt_len_q  <= '0;
            ack_q      <= 1'b0;
            rst_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            accept_q   <= accept_d;
            cnt_q      <= cnt_d;
            ok_q       <= ok_d;
            pid_q      <= pid_d;
            addr_q     <= addr_d;
            endp_q     <= endp_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_pid_q  <= pkt_pid_d;
            tok_addr_q <= tok_addr_d;
            tok_endp_q <= tok_endp_d;
            pkt_len_q  <= pkt_len_d;
            ack_q      <= ack_d;
            rst_seen_q <= bus.usbResetDetect;
        end
    end

    assign bus.rxAcceptNewData = accept_q;
    assign bus.bufWrEn         = wr_en_q;
    assign bus.bufWrData       = wr_data_q;
    assign bus.pktDone         = done_q;
    assign bus.pktOk           = pkt_ok_q;
    assign bus.pktPid          = pkt_pid_q;
    assign bus.tokAddr         = tok_addr_q;
    assign bus.tokEndp         = tok_endp_q;
    assign bus.pktLen          = pkt_len_q;
    assign bus.ACK_USB_RST     = ack_q;
    assign bus.busReset        = ack_q;
endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// tb/tb_usb_rx_packet_ctrl.sv - self-checking bench for usb_rx_packet_ctrl against a packet-level model
module tb_usb_rx_packet_ctrl;
    localparam int MAXP = 4;

    typedef struct {
        logic       ok;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        int         len;
    } res_t;

    logic clk;
    logic rst_n;
    usb_rx_packet_ctrl_if #(.CNT_W(11)) bus ();

    usb_rx_packet_ctrl #(.MAX_PAYLOAD(MAXP), .CNT_W(11)) dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         chk_en  = 0;
    bit         toggle_en = 0;
    int         cyc = 0;
    int         done_due = -1;
    int         done_cnt = 0;
    int         ack_cnt = 0;
    int         wr_cnt = 0;
    logic       last_ok = 0;
    logic       exp_ack = 0;
    logic       m_seen = 0;
    logic [3:0] e_pid = 0;
    logic [6:0] e_addr = 0;
    logic [3:0] e_endp = 0;
    int         e_len = 0;
    logic [6:0] m_addr = 0;
    logic [3:0] m_endp = 0;
    logic [7:0] pkt[$];
    logic [7:0] wr_q[$];
    res_t       res_q[$];
    res_t       r;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Packet-level expectation: result fields, length and the bytes that must reach the buffer.
    task automatic model_pkt(input bit keep);
        res_t       m;
        int         n;
        logic [7:0] p, b1, b2;
        n = pkt.size() - 1;
        p = pkt[0];
        b1 = (n >= 1) ? pkt[1] : 8'h00;
        b2 = (n >= 2) ? pkt[2] : 8'h00;
        m.ok  = 0;
        m.pid = p[3:0];
        m.len = (n > MAXP + 3) ? MAXP + 3 : n;
        if (p[7:4] == ~p[3:0]) begin
            if (p[1:0] == 2'b10) begin
                m.ok = (n == 0) && keep;
            end else if (p[1:0] == 2'b01) begin
                if (n >= 1) begin
                    m_addr    = b1[6:0];
                    m_endp[0] = b1[7];
                end
                if (n >= 2) m_endp[3:1] = b2[2:0];
                m.ok = (n == 2) && keep;
            end else if (p[1:0] == 2'b11) begin
                for (int i = 1; i <= n && i <= MAXP + 2; i++) wr_q.push_back(pkt[i]);
                m.ok = keep && (n >= 2) && (n <= MAXP + 2);
            end
        end
        m.addr = m_addr;
        m.endp = m_endp;
        res_q.push_back(m);
    endtask

    task automatic drive(input int cnt, input bit mark_last, input bit keep, input bit drop_en);
        bit got;
        for (int i = 0; i < cnt; i++) begin
            bus.rxData       = pkt[i];
            bus.rxIsLastByte = mark_last && (i == cnt - 1);
            bus.keepPacket   = keep;
            bus.rxDataValid  = 1;
            got = 0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(negedge clk);
                got = bus.rxAcceptNewData;
                @(posedge clk);
                #1;
            end
            if (!got) fail("accept_timeout");
            if (drop_en && i == 0) bus.rxEnable = 0;
        end
        bus.rxDataValid  = 0;
        bus.rxIsLastByte = 0;
        bus.keepPacket   = 0;
    endtask

    task automatic send(input bit keep, input bit tog, input bit drop_en);
        model_pkt(keep);
        toggle_en = tog;
        drive(pkt.size(), 1, keep, drop_en);
        toggle_en = 0;
        bus.rxEnable = 1;
        idle(6);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_accept"}, bus.rxAcceptNewData, 0);
        chk({tag, "_wren"},   bus.bufWrEn, 0);
        chk({tag, "_wrdata"}, bus.bufWrData, 0);
        chk({tag, "_done"},   bus.pktDone, 0);
        chk({tag, "_ok"},     bus.pktOk, 0);
        chk({tag, "_ack"},    bus.ACK_USB_RST, 0);
        chk({tag, "_busrst"}, bus.busReset, 0);
        chk({tag, "_pid"},    bus.pktPid, 0);
        chk({tag, "_addr"},   bus.tokAddr, 0);
        chk({tag, "_endp"},   bus.tokEndp, 0);
        chk({tag, "_len"},    bus.pktLen, 0);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            if (bus.rxDataValid === 1'b1 || bus.rxDataValid === 1'b0) begin
                // bufFull stimulus: alternates while enabled, otherwise held low
                @(posedge clk);
                #1;
                bus.bufFull = toggle_en ? ~bus.bufFull : 1'b0;
            end else begin
                @(posedge clk);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cyc++;
                if (bus.pktDone) begin
                    done_cnt++;
                    last_ok = bus.pktOk;
                end
                if (cyc == done_due) begin
                    chk("pktDone_at_2", bus.pktDone, 1);
                    if (res_q.size() == 0) begin
                        fail("result_not_expected");
                    end else begin
                        r = res_q.pop_front();
                        chk("pktOk", bus.pktOk, r.ok);
                        e_pid  = r.pid;
                        e_addr = r.addr;
                        e_endp = r.endp;
                        e_len  = r.len;
                    end
                    done_due = -1;
                end else begin
                    chk("pktDone_quiet", bus.pktDone, 0);
                end
                chk("pktPid", bus.pktPid, e_pid);
                chk("tokAddr", bus.tokAddr, e_addr);
                chk("tokEndp", bus.tokEndp, e_endp);
                chk("pktLen", bus.pktLen, e_len);
                if (bus.bufWrEn) begin
                    wr_cnt++;
                    chk("write_while_full", bus.bufFull, 0);
                    if (wr_q.size() == 0) fail("write_not_expected");
                    else chk("bufWrData", bus.bufWrData, wr_q.pop_front());
                end
                chk("ACK_USB_RST", bus.ACK_USB_RST, exp_ack);
                chk("busReset", bus.busReset, exp_ack);
                if (bus.ACK_USB_RST) ack_cnt++;
                exp_ack = bus.usbResetDetect && !m_seen;
                m_seen  = bus.usbResetDetect;
                if (bus.rxDataValid && bus.rxAcceptNewData && bus.rxIsLastByte) done_due = cyc + 2;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, a0;
        rst_n = 0;
        bus.usbResetDetect = 0;
        bus.rxDataValid    = 1;
        bus.rxData         = 8'hD2;
        bus.rxIsLastByte   = 1;
        bus.keepPacket     = 1;
        bus.rxEnable       = 1;
        bus.bufFull        = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        bus.rxDataValid  = 0;
        bus.rxIsLastByte = 0;
        bus.keepPacket   = 0;
        rst_n  = 1;
        chk_en = 1;
        idle(3);

        // ACK handshake
        w0 = wr_cnt;
        pkt = {8'hD2};
        send(1, 0, 0);
        chk("ack_ok", last_ok, 1);
        chk("ack_pid", bus.pktPid, 2);
        chk("ack_len", bus.pktLen, 0);
        chk("ack_writes", wr_cnt - w0, 0);

        // IN token, rxEnable dropped after the PID
        pkt = {8'h69, 8'h85, 8'h0B};
        send(1, 0, 1);
        chk("in_ok", last_ok, 1);
        chk("in_addr", bus.tokAddr, 7'h05);
        chk("in_endp", bus.tokEndp, 4'h7);
        chk("in_len", bus.pktLen, 2);

        // DATA0 with bufFull alternating
        w0 = wr_cnt;
        pkt = {8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A};
        send(1, 1, 0);
        chk("data_writes", wr_cnt - w0, 6);
        chk("data_ok", last_ok, 1);
        chk("data_len", bus.pktLen, 6);
        chk("data_pid", bus.pktPid, 3);

        // bad PID drains
        w0 = wr_cnt;
        pkt = {8'hC4, 8'hAA, 8'hBB, 8'hCC};
        send(1, 0, 0);
        chk("bad_ok", last_ok, 0);
        chk("bad_len", bus.pktLen, 3);
        chk("bad_writes", wr_cnt - w0, 0);

        // overflow past payload+CRC
        w0 = wr_cnt;
        pkt = {8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send(1, 0, 0);
        chk("ovf_writes", wr_cnt - w0, 6);
        chk("ovf_ok", last_ok, 0);
        chk("ovf_len", bus.pktLen, 7);

        // assorted failing packets checked by the model
        pkt = {8'hD2};                      send(0, 0, 0);
        pkt = {8'hD2, 8'h00};               send(1, 0, 0);
        pkt = {8'h69, 8'h85};               send(1, 0, 0);
        pkt = {8'h69, 8'h12, 8'h03, 8'h44}; send(1, 0, 0);
        pkt = {8'hC3, 8'h10, 8'h20, 8'h30}; send(0, 0, 0);
        pkt = {8'h4B, 8'h77};               send(1, 0, 0);
        pkt = {8'h4B, 8'h10, 8'h20};        send(1, 1, 0);

        // rxEnable low in IDLE blocks acceptance
        bus.rxEnable = 0;
        idle(2);
        bus.rxData      = 8'hD2;
        bus.rxDataValid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gated_accept", bus.rxAcceptNewData, 0);
            @(posedge clk);
            #1;
        end
        bus.rxDataValid = 0;
        bus.rxEnable    = 1;
        idle(3);

        // bus reset in the middle of a DATA packet
        d0 = done_cnt;
        a0 = ack_cnt;
        pkt = {8'hC3, 8'h11, 8'h22, 8'h33};
        wr_q.push_back(8'h11);
        wr_q.push_back(8'h22);
        drive(3, 0, 1, 0);
        idle(3);
        bus.usbResetDetect = 1;
        idle(10);
        bus.usbResetDetect = 0;
        idle(4);
        chk("busrst_ack_count", ack_cnt - a0, 1);
        chk("busrst_no_done", done_cnt - d0, 0);
        pkt = {8'hD2};
        send(1, 0, 0);
        chk("post_rst_ok", last_ok, 1);
        chk("post_rst_pid", bus.pktPid, 2);
        chk("post_rst_done", done_cnt - d0, 1);

        if (res_q.size() != 0) fail("results_left_over");
        if (wr_q.size() != 0) fail("writes_left_over");
        if (done_due != -1) fail("pktDone_missing");

        // reset clears held fields and wins over usbResetDetect
        chk_en = 0;
        rst_n = 0;
        bus.usbResetDetect = 1;
        idle(2);
        @(negedge clk);
        chk_reset_outputs("reset2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
